// File: rtl/cache_ctrl.sv
// cache_ctrl: sequences one CPU load/store at a time through a registered-lookup
// cache and a handshaked backing memory. Read misses fill the cache; writes go
// to the cache first and then through to memory.
// Optional hit/miss statistics are built when CACHE_CTRL_STATS_EN is defined;
// otherwise hit_cnt and miss_cnt are tied to zero.
module cache_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  cache_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [STAT_WIDTH-1:0] hit_cnt,
  output logic [STAT_WIDTH-1:0] miss_cnt
);

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_RD,
    CWRITE,
    FILL,
    SETTLE,
    MEM_WR,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] cwdata_q, cwdata_d;

  // State and request/response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cwdata_q <= cwdata_d;
    end
  end

  // Next-state, data capture and state-decoded strobes
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cwdata_d = cwdata_q;
    cpu_busy = 1'b1;
    cpu_done = 1'b0;
    cache_we = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_busy = 1'b0;
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (cpu_we) begin
            cwdata_d = cpu_wdata;
            state_d  = CWRITE;
          end else begin
            state_d  = LOOKUP;
          end
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (cache_hit) begin
          rdata_d = cache_rdata;
          state_d = DONE;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          rdata_d  = mem_rdata;
          cwdata_d = mem_rdata;
          state_d  = FILL;
        end
      end
      CWRITE: begin
        cache_we = 1'b1;
        state_d  = SETTLE;
      end
      FILL: begin
        cache_we = 1'b1;
        state_d  = SETTLE;
      end
      SETTLE: state_d = we_q ? MEM_WR : DONE;
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = DONE;
      end
      DONE: begin
        cpu_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdata   = rdata_q;
  assign cache_addr  = addr_q;
  assign cache_wdata = cwdata_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

`ifdef CACHE_CTRL_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

  logic [STAT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  // Saturating read hit/miss counts, updated on the lookup-result cycle
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == CHECK) begin
      if (cache_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + STAT_ONE;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + STAT_ONE;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
